// File: rtl/audio_i2s_pkg.sv
// Shared types and format helpers for the I2S codec emulator.
// Format select: define I2S_EMU_LEFT_JUSTIFIED_EN for left-justified, otherwise standard I2S.
package audio_i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

`ifdef I2S_EMU_LEFT_JUSTIFIED_EN
    localparam logic LRCK_LEFT   = 1'b1;
    localparam int   DATA_OFFSET = 0;
`else
    localparam logic LRCK_LEFT   = 1'b0;
    localparam int   DATA_OFFSET = 1;
`endif

    // Sample bit carried at slot position p (MSB first), or -1 when the slot is padding.
    function automatic int bit_index(input int p, input int sample_w);
        if (p >= DATA_OFFSET && p < DATA_OFFSET + sample_w)
            return sample_w - 1 - (p - DATA_OFFSET);
        return -1;
    endfunction

endpackage

// File: rtl/audio_codec_i2s_emulator_clock_gen.sv
// BCLK divider, frame bit counter and run/idle FSM for the I2S emulator.
// Edge and frame strobes are single-cycle and qualify the registered outputs in the top.
module i2s_clock_gen
    import audio_i2s_pkg::*;
#(
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    output logic                          bclk,
    output logic [$clog2(2*SLOT_W)-1:0]   bit_cnt,
    output logic                          bclk_rise,
    output logic                          bclk_fall,
    output logic                          frame_start,
    output logic                          frame_end
);

    localparam int BC_W  = $clog2(2*SLOT_W);
    localparam int DIV_W = $clog2(BCLK_DIV);

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick        = (state == RUN) && (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign bclk_rise   = tick && !bclk;
    assign bclk_fall   = tick && bclk;
    assign frame_end   = bclk_fall && (bit_cnt == BC_W'(2*SLOT_W - 1));
    assign frame_start = enable && ((state == IDLE) || frame_end);

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
        end else if (frame_start) begin
            state   <= RUN;
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
        end else if (frame_end) begin
            state   <= IDLE;
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            bclk    <= !bclk;
            if (bclk_fall)
                bit_cnt <= bit_cnt + 1'b1;
        end else if (state == RUN) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_codec_i2s_emulator.sv
// Codec-side I2S link partner: clock master, ADC serializer with pending-pair handshake, DAC deserializer.
// Format select: define I2S_EMU_LEFT_JUSTIFIED_EN for left-justified, otherwise standard I2S.
module audio_codec_i2s_emulator
    import audio_i2s_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] adc_l_data,
    input  logic [SAMPLE_W-1:0] adc_r_data,
    input  logic                adc_valid,
    output logic                adc_ready,
    output logic                underrun,
    output logic                audio_BCLK,
    output logic                audio_ADCLRCK,
    output logic                audio_DACLRCK,
    output logic                audio_ADCDAT,
    input  logic                audio_DACDAT,
    output logic [SAMPLE_W-1:0] dac_l_data,
    output logic [SAMPLE_W-1:0] dac_r_data,
    output logic                dac_valid
);

    localparam int BC_W  = $clog2(2*SLOT_W);
    localparam int IDX_W = $clog2(SAMPLE_W);

    logic            bclk, bclk_rise, bclk_fall, frame_start, frame_end;
    logic [BC_W-1:0] bit_cnt;

    i2s_clock_gen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clock_gen (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bclk        (bclk),
        .bit_cnt     (bit_cnt),
        .bclk_rise   (bclk_rise),
        .bclk_fall   (bclk_fall),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    assign audio_BCLK    = bclk;
    assign audio_DACLRCK = audio_ADCLRCK;

    logic [SAMPLE_W-1:0] pend_l, pend_r, tx_l, tx_r, src_l, src_r;
    logic [SAMPLE_W-1:0] rx_l, rx_r, rx_r_next;
    logic                pend_full, going_idle, tx_left, tx_bit, cap_left, cap_en;
    int                  next_bit, tx_idx, cap_idx;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        going_idle = frame_end && !enable;
        next_bit   = frame_start ? 0 : int'(bit_cnt) + 1;
        tx_left    = next_bit < SLOT_W;
        tx_idx     = bit_index(next_bit % SLOT_W, SAMPLE_W);
        // The first bit of a frame must come from the pair being loaded in that same cycle.
        src_l      = (frame_start && pend_full) ? pend_l : tx_l;
        src_r      = (frame_start && pend_full) ? pend_r : tx_r;
        tx_bit     = 1'b0;
        if (tx_idx >= 0)
            tx_bit = tx_left ? src_l[tx_idx[IDX_W-1:0]] : src_r[tx_idx[IDX_W-1:0]];
        cap_left   = int'(bit_cnt) < SLOT_W;
        cap_idx    = bit_index(int'(bit_cnt) % SLOT_W, SAMPLE_W);
        cap_en     = bclk_rise && (cap_idx >= 0);
        rx_r_next  = {rx_r[SAMPLE_W-2:0], audio_DACDAT};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_full <= 1'b0;
            pend_l    <= '0;
            pend_r    <= '0;
            tx_l      <= '0;
            tx_r      <= '0;
            adc_ready <= 1'b1;
            underrun  <= 1'b0;
        end else begin
            underrun <= frame_start && !pend_full;
            if (frame_start && pend_full) begin
                tx_l      <= pend_l;
                tx_r      <= pend_r;
                pend_full <= 1'b0;
                adc_ready <= 1'b1;
            end else if (adc_valid && adc_ready) begin
                pend_l    <= adc_l_data;
                pend_r    <= adc_r_data;
                pend_full <= 1'b1;
                adc_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            audio_ADCLRCK <= 1'b1;
            audio_ADCDAT  <= 1'b0;
        end else if (going_idle) begin
            audio_ADCLRCK <= 1'b1;
            audio_ADCDAT  <= 1'b0;
        end else if (frame_start || bclk_fall) begin
            audio_ADCLRCK <= tx_left ? LRCK_LEFT : !LRCK_LEFT;
            audio_ADCDAT  <= tx_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_l       <= '0;
            rx_r       <= '0;
            dac_l_data <= '0;
            dac_r_data <= '0;
            dac_valid  <= 1'b0;
        end else begin
            dac_valid <= 1'b0;
            if (cap_en && cap_left) begin
                rx_l <= {rx_l[SAMPLE_W-2:0], audio_DACDAT};
            end else if (cap_en) begin
                rx_r <= rx_r_next;
                if (cap_idx == 0) begin
                    dac_l_data <= rx_l;
                    dac_r_data <= rx_r_next;
                    dac_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_codec_i2s_emulator.sv
// Directed bench for audio_codec_i2s_emulator (default parameters, standard I2S format).
// Uses a loopback of ADCDAT to DACDAT and a table of sample pairs with hand-computed results.
module tb_audio_codec_i2s_emulator;

    localparam int  SAMPLE_W  = 24;
    localparam int  FRAME_CLK = 1024;
    localparam time CLK_T     = 10;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic                adc_valid = 1'b0;
    logic                loop_en = 1'b0;
    logic [SAMPLE_W-1:0] adc_l_data = '0;
    logic [SAMPLE_W-1:0] adc_r_data = '0;
    logic                adc_ready, underrun, dac_valid;
    logic                audio_BCLK, audio_ADCLRCK, audio_DACLRCK, audio_ADCDAT, audio_DACDAT;
    logic [SAMPLE_W-1:0] dac_l_data, dac_r_data;

    assign audio_DACDAT = loop_en ? audio_ADCDAT : 1'b0;

    audio_codec_i2s_emulator dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .adc_l_data    (adc_l_data),
        .adc_r_data    (adc_r_data),
        .adc_valid     (adc_valid),
        .adc_ready     (adc_ready),
        .underrun      (underrun),
        .audio_BCLK    (audio_BCLK),
        .audio_ADCLRCK (audio_ADCLRCK),
        .audio_DACLRCK (audio_DACLRCK),
        .audio_ADCDAT  (audio_ADCDAT),
        .audio_DACDAT  (audio_DACDAT),
        .dac_l_data    (dac_l_data),
        .dac_r_data    (dac_r_data),
        .dac_valid     (dac_valid)
    );

    always #(CLK_T/2) clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int dv_cnt   = 0;
    int un_cnt   = 0;

    always @(negedge clk) begin
        if (dac_valid === 1'b1) dv_cnt++;
        if (underrun === 1'b1) un_cnt++;
    end

    typedef struct {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
        bit                  feed;
        logic [SAMPLE_W-1:0] exp_l;
        logic [SAMPLE_W-1:0] exp_r;
        int                  exp_un;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        adc_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
        bit ok;
        ok = 1'b0;
        adc_l_data = l;
        adc_r_data = r;
        adc_valid  = 1'b1;
        for (int i = 0; i < 2100; i++) begin
            if (adc_ready === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        adc_valid = 1'b0;
        check("push_handshake", 64'(ok), 64'd1);
    endtask

    task automatic wait_lrck_fall(output time t);
        logic prev;
        bit   ok;
        ok   = 1'b0;
        t    = 0;
        prev = audio_ADCLRCK;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && audio_ADCLRCK === 1'b0) begin
                ok = 1'b1;
                t  = $time;
                break;
            end
            prev = audio_ADCLRCK;
        end
        check("lrck_fall_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_falls(input int n);
        logic prev;
        int   cnt;
        cnt  = 0;
        prev = audio_BCLK;
        for (int i = 0; i < 2100 && cnt < n; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && audio_BCLK === 1'b0) cnt++;
            prev = audio_BCLK;
        end
        check("bclk_falls_seen", 64'(cnt), 64'(n));
    endtask

    task automatic wait_dac_valid(output time t);
        bit ok;
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (dac_valid === 1'b1) begin
                ok = 1'b1;
                t  = $time;
                break;
            end
        end
        check("dac_valid_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        time                 t0, t1, t_prev, t_dv, last_fall;
        logic [31:0]         lw, rw;
        logic                prev, lr_ok;
        int                  rises, un_before, dv_before;

        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 1'b1, 24'hA5A5A5, 24'h5A5A5A, 0};
        vecs[1] = '{24'h123456, 24'hABCDEF, 1'b1, 24'h123456, 24'hABCDEF, 0};
        vecs[2] = '{24'hFFFFFF, 24'h000000, 1'b1, 24'hFFFFFF, 24'h000000, 0};
        vecs[3] = '{24'h800001, 24'h7FFFFE, 1'b1, 24'h800001, 24'h7FFFFE, 0};
        vecs[4] = '{24'h0,      24'h0,      1'b0, 24'h800001, 24'h7FFFFE, 1};
        vecs[5] = '{24'h0,      24'h0,      1'b0, 24'h800001, 24'h7FFFFE, 1};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_bclk",     64'(audio_BCLK),    64'd0);
        check("rst_adclrck",  64'(audio_ADCLRCK), 64'd1);
        check("rst_daclrck",  64'(audio_DACLRCK), 64'd1);
        check("rst_adcdat",   64'(audio_ADCDAT),  64'd0);
        check("rst_ready",    64'(adc_ready),     64'd1);
        check("rst_underrun", 64'(underrun),      64'd0);
        check("rst_dac_l",    64'(dac_l_data),    64'd0);
        check("rst_dac_r",    64'(dac_r_data),    64'd0);
        check("rst_dac_valid",64'(dac_valid),     64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Serial format of one frame and frame length
        push(24'hA5A5A5, 24'h5A5A5A);
        check("ready_after_xfer", 64'(adc_ready), 64'd0);
        un_before = un_cnt;
        enable = 1'b1;
        wait_lrck_fall(t0);
        check("ready_after_load", 64'(adc_ready), 64'd1);
        lw = '0; rw = '0; lr_ok = 1'b1; rises = 0; prev = audio_BCLK;
        for (int i = 0; i < 2100 && rises < 64; i++) begin
            @(negedge clk);
            if (prev === 1'b0 && audio_BCLK === 1'b1) begin
                if (rises < 32) begin
                    lw = {lw[30:0], audio_ADCDAT};
                    if (audio_ADCLRCK !== 1'b0) lr_ok = 1'b0;
                end else begin
                    rw = {rw[30:0], audio_ADCDAT};
                    if (audio_ADCLRCK !== 1'b1) lr_ok = 1'b0;
                end
                rises++;
            end
            prev = audio_BCLK;
        end
        check("frame_rises",  64'(rises), 64'd64);
        check("slot_left",    64'(lw), 64'({1'b0, 24'hA5A5A5, 7'b0}));
        check("slot_right",   64'(rw), 64'({1'b0, 24'h5A5A5A, 7'b0}));
        check("lrck_levels",  64'(lr_ok), 64'd1);
        check("no_underrun_first", 64'(un_cnt - un_before), 64'd0);
        wait_lrck_fall(t1);
        check("frame_length", 64'((t1 - t0) / CLK_T), 64'(FRAME_CLK));

        // Loopback table: fed pairs, then starvation with retransmission
        do_reset();
        loop_en = 1'b1;
        @(negedge clk);
        push(vecs[0].l, vecs[0].r);
        enable = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            un_before = un_cnt;
            if (i > 0 && vecs[i].feed) push(vecs[i].l, vecs[i].r);
            wait_dac_valid(t_dv);
            check($sformatf("vec%0d_dac_l", i), 64'(dac_l_data), 64'(vecs[i].exp_l));
            check($sformatf("vec%0d_dac_r", i), 64'(dac_r_data), 64'(vecs[i].exp_r));
            check($sformatf("vec%0d_underrun", i), 64'(un_cnt - un_before), 64'(vecs[i].exp_un));
            if (i > 0)
                check($sformatf("vec%0d_dv_period", i), 64'((t_dv - t_prev) / CLK_T), 64'(FRAME_CLK));
            t_prev = t_dv;
        end

        // adc_valid exactly in the frame-start cycle with pending empty
        wait_lrck_fall(t0);
        repeat (FRAME_CLK - 1) @(negedge clk);
        check("pre_start_lrck", 64'(audio_ADCLRCK), 64'd1);
        adc_l_data = 24'h0F0F0F;
        adc_r_data = 24'hF0F0F0;
        adc_valid  = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        check("start_lrck",     64'(audio_ADCLRCK), 64'd0);
        check("start_underrun", 64'(underrun),      64'd1);
        check("start_xfer",     64'(adc_ready),     64'd0);
        wait_dac_valid(t_dv);
        check("bypass_dac_l", 64'(dac_l_data), 64'h800001);
        check("bypass_dac_r", 64'(dac_r_data), 64'h7FFFFE);
        un_before = un_cnt;
        wait_dac_valid(t_dv);
        check("next_dac_l",   64'(dac_l_data), 64'h0F0F0F);
        check("next_dac_r",   64'(dac_r_data), 64'hF0F0F0);
        check("next_underrun",64'(un_cnt - un_before), 64'd0);

        // Enable dropped at bit_cnt=10: frame runs to completion, then idle
        wait_lrck_fall(t0);
        wait_falls(10);
        enable = 1'b0;
        rises = 0; last_fall = 0; prev = audio_BCLK;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (prev === 1'b0 && audio_BCLK === 1'b1) rises++;
            if (prev === 1'b1 && audio_BCLK === 1'b0) last_fall = $time;
            prev = audio_BCLK;
        end
        check("stop_rises",     64'(rises), 64'd54);
        check("stop_frame_end", 64'((last_fall - t0) / CLK_T), 64'(FRAME_CLK));
        check("idle_bclk",      64'(audio_BCLK),    64'd0);
        check("idle_lrck",      64'(audio_ADCLRCK), 64'd1);
        check("idle_adcdat",    64'(audio_ADCDAT),  64'd0);

        // Reset at bit_cnt=40: immediate return to reset values, frame discarded
        enable = 1'b1;
        wait_lrck_fall(t0);
        wait_falls(40);
        dv_before = dv_cnt;
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("mid_rst_bclk",  64'(audio_BCLK),    64'd0);
        check("mid_rst_lrck",  64'(audio_ADCLRCK), 64'd1);
        check("mid_rst_dlrck", 64'(audio_DACLRCK), 64'd1);
        check("mid_rst_adcdat",64'(audio_ADCDAT),  64'd0);
        check("mid_rst_ready", 64'(adc_ready),     64'd1);
        check("mid_rst_under", 64'(underrun),      64'd0);
        check("mid_rst_dac_l", 64'(dac_l_data),    64'd0);
        check("mid_rst_dac_r", 64'(dac_r_data),    64'd0);
        reset = 1'b0;
        repeat (1100) @(negedge clk);
        check("mid_rst_no_dv", 64'(dv_cnt - dv_before), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
